recovery_drain: RTL

RECOVERY_DRAIN -- requirements
Module: recovery_drain

---
 rtl/recovery_drain_pkg.sv | 6 +
 rtl/drain_counter.sv | 30 +++
 rtl/recovery_drain.sv | 70 +++++++
 3 files changed

// File: rtl/recovery_drain_pkg.sv
// recovery_drain_pkg: shared drain state encoding and sizing defaults
package recovery_drain_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int CW_DEF = 4;
    typedef enum logic [1:0] {IDLE, READ, WRITE, FIN} drain_state_t;
endpackage

// File: rtl/drain_counter.sv
// drain_counter: entry index and remaining-entry count for a recovery drain
module drain_counter
    import recovery_drain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     load,
    input  logic                     step,
    input  logic [CW-1:0]            count,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     last
);
    logic [CW-1:0] rem;
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            idx <= '0;
            rem <= '0;
        end else if (load) begin
            idx <= '0;
            rem <= count > CW'(DEPTH) ? CW'(DEPTH) : count;
        end else if (step) begin
            idx <= idx + 1'b1;
            rem <= rem - 1'b1;
        end
    end
    assign last = rem == CW'(1);
endmodule

// File: rtl/recovery_drain.sv
// recovery_drain: commits or discards buffered recovery stores into data memory
module recovery_drain
    import recovery_drain_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CW = CW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     start,
    input  logic                     discard,
    input  logic [CW-1:0]            rr_count,
    output logic [$clog2(DEPTH)-1:0] rr_idx,
    input  logic [31:0]              rr_addr,
    input  logic [31:0]              rr_data,
    output logic                     dm_WE,
    output logic [31:0]              dm_A,
    output logic [31:0]              dm_WD,
    output logic                     busy,
    output logic                     done,
    output logic                     rr_clear,
    output logic                     misalign_err
);
    drain_state_t state, state_nxt;
    logic [31:0] hold_a, hold_d;
    logic err_q, err_set, load, step, last, writing;
    assign load = state == IDLE && start && !discard;
    assign step = state == WRITE;
    drain_counter #(.DEPTH(DEPTH), .CW(CW)) u_cnt (
        .clk(clk),
        .rst_in(rst_in),
        .load(load),
        .step(step),
        .count(rr_count),
        .idx(rr_idx),
        .last(last)
    );
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = discard ? FIN : !start ? IDLE : rr_count == '0 ? FIN : READ;
            READ:    state_nxt = discard ? FIN : WRITE;
            WRITE:   state_nxt = discard || last ? FIN : READ;
            default: state_nxt = IDLE;
        endcase
    end
    // a misaligned entry is consumed without a write; the flag shows in its own WRITE cycle
    assign writing = state == WRITE && !discard;
    assign dm_WE = writing && hold_a[1:0] == 2'b00;
    assign err_set = writing && hold_a[1:0] != 2'b00;
    assign dm_A = dm_WE ? hold_a : '0;
    assign dm_WD = dm_WE ? hold_d : '0;
    assign busy = state != IDLE;
    assign done = state == FIN;
    assign rr_clear = state == FIN;
    assign misalign_err = err_q || err_set;
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            hold_a <= '0;
            hold_d <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            hold_a <= state == READ ? rr_addr : hold_a;
            hold_d <= state == READ ? rr_data : hold_d;
            err_q <= load ? 1'b0 : err_q || err_set;
        end
    end
endmodule
